// File: rtl/sw_pkg.sv
// Shared switch-conditioning constants and types for the sw_debounce slice.
package sw_pkg;

    localparam int SW_WIDTH              = 16;
    localparam int CLK_HZ                = 100_000_000;
    localparam int DEBOUNCE_MS           = 10;
    localparam int STABLE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef logic [SW_WIDTH-1:0] sw_vec_t;

    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_QUALIFY = 1'b1
    } db_state_t;

    // Counter only has to reach STABLE_CYCLES-1, so $clog2 bits suffice (min 1).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, stability counter, debounced
// level and registered rise/fall pulses. rise_next/fall_next feed top-level state.
module debounce_bit
    import sw_pkg::*;
#(
    parameter int   STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic sw_db,
    output logic rise,
    output logic fall,
    output logic rise_next,
    output logic fall_next
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1_reg;
    logic          s2_reg;
    logic          db_reg;
    logic          db_next;
    logic          rise_reg;
    logic          fall_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    db_state_t     state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= RESET_VAL;
            s2_reg   <= RESET_VAL;
            db_reg   <= RESET_VAL;
            cnt_reg  <= '0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            s1_reg   <= sw;
            s2_reg   <= s1_reg;
            db_reg   <= db_next;
            cnt_reg  <= cnt_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    // Any sample matching the accepted level drops back to IDLE, which clears
    // the counter, so a bounce restarts qualification from zero.
    always_comb begin
        state     = (s2_reg != db_reg) ? DB_QUALIFY : DB_IDLE;
        cnt_next  = '0;
        db_next   = db_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        unique case (state)
            DB_IDLE: begin
                cnt_next = '0;
            end
            DB_QUALIFY: begin
                if (cnt_reg == CNT_LAST) begin
                    db_next   = s2_reg;
                    rise_next = s2_reg;
                    fall_next = ~s2_reg;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
        endcase
    end

    assign sw_db = db_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer with change pulses ahead of the adder datapath.
// Define SW_DEBOUNCE_TOGGLE_EN to add the push-button toggle output.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int               WIDTH         = SW_WIDTH,
    parameter int               STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
`ifdef SW_DEBOUNCE_TOGGLE_EN
    output logic [WIDTH-1:0] toggle,
`endif
    output logic             changed
);

    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;
    logic             changed_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .RESET_VAL     (RESET_VAL[gi])
            ) u_bit (
                .clk       (clk),
                .rst_n     (rst_n),
                .sw        (sw[gi]),
                .sw_db     (sw_db[gi]),
                .rise      (rise[gi]),
                .fall      (fall[gi]),
                .rise_next (rise_next[gi]),
                .fall_next (fall_next[gi])
            );
        end
    endgenerate

    // Built from next-state pulses so changed lines up with rise/fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |(rise_next | fall_next);
        end
    end

    assign changed = changed_reg;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic [WIDTH-1:0] toggle_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_reg <= '0;
        end else begin
            toggle_reg <= toggle_reg ^ rise_next;
        end
    end

    assign toggle = toggle_reg;
`endif

endmodule
